seq_add_sub: RTL and testbench

- Parametrised, multi-cycle two's-complement adder/subtractor.
- Processes CHUNK bits per clock through a combinational chunk adder, so the carry chain is CHUNK bits long instead of WIDTH bits.
- Sits in the datapath beside the ALU for wide operands where a full-width carry chain misses timing.
- Valid/ready handshake on both input and output, plus add/sub mode and status flags (carry, overflow, zero, negative).

---
 rtl/seq_add_sub_pkg.sv | 28 ++
 rtl/seq_add_sub_if.sv | 50 +++++
 rtl/full_adder.sv | 14 +
 rtl/seq_add_sub_chunk_adder.sv | 31 +++
 rtl/seq_add_sub.sv | 123 ++++++++++++
 tb/tb_seq_add_sub.sv | 333 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/seq_add_sub_pkg.sv
// Shared types for the multi-cycle adder/subtractor.
// FSM encoding, mode constants and the status flag bundle.
package seq_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  localparam flags_t FLAGS_CLR = '{
    cout: 1'b0,
    ovf:  1'b0,
    zero: 1'b0,
    neg:  1'b0
  };

endpackage

// File: rtl/seq_add_sub_if.sv
// Request/response bundle of seq_add_sub.
// master drives operands and result acceptance; slave is the block.
interface seq_add_sub_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid,
    output a,
    output b,
    output sub,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout,
    input  ovf,
    input  zero,
    input  neg
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  sub,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout,
    output ovf,
    output zero,
    output neg
  );

endinterface

// File: rtl/full_adder.sv
// One-bit full-adder cell.
// Building block of the ripple chunk adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_add_sub_chunk_adder.sv
// W-bit ripple adder made of full_adder cells.
// Also exposes the carry into its MSB for signed overflow.
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[W];
  assign cmsb = c[W-1];

endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle add/sub: CHUNK bits per clock through one chunk adder.
// Partial sums shift into op_a from the top as op_a empties.
module seq_add_sub
  import seq_add_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic        clk,
  input logic        rst,
  seq_add_sub_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH ||
      (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("seq_add_sub: WIDTH must be a multiple of CHUNK");
  end

  state_t           state, state_n;
  logic [WIDTH-1:0] op_a, op_a_n;
  logic [WIDTH-1:0] op_b, op_b_n;
  logic             carry, carry_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sum_q, sum_n;
  flags_t           flags, flags_n;

  logic [CHUNK-1:0] cs;
  logic             cc;
  logic             cmsb;
  logic [WIDTH-1:0] res;

  chunk_adder #(
    .W (CHUNK)
  ) u_chunk (
    .a    (op_a[CHUNK-1:0]),
    .b    (op_b[CHUNK-1:0]),
    .cin  (carry),
    .s    (cs),
    .cout (cc),
    .cmsb (cmsb)
  );

  // After NCHUNK steps res holds the whole sum, LSB chunk lowest.
  assign res = (WIDTH'(cs) << (WIDTH - CHUNK)) |
               (op_a >> CHUNK);

  always_comb begin
    state_n = state;
    op_a_n  = op_a;
    op_b_n  = op_b;
    carry_n = carry;
    cnt_n   = cnt;
    sum_n   = sum_q;
    flags_n = flags;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          op_a_n  = bus.a;
          op_b_n  = (bus.sub == MODE_SUB) ?
                    ~bus.b : bus.b;
          carry_n = (bus.sub == MODE_SUB);
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        op_a_n  = res;
        op_b_n  = op_b >> CHUNK;
        carry_n = cc;
        cnt_n   = cnt + CW'(1);
        if (cnt == LAST) begin
          sum_n        = res;
          flags_n.cout = cc;
          flags_n.ovf  = cmsb ^ cc;
          flags_n.zero = (res == '0);
          flags_n.neg  = res[WIDTH-1];
          state_n      = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum_q <= '0;
      flags <= FLAGS_CLR;
    end else begin
      state <= state_n;
      op_a  <= op_a_n;
      op_b  <= op_b_n;
      carry <= carry_n;
      cnt   <= cnt_n;
      sum_q <= sum_n;
      flags <= flags_n;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = flags.cout;
  assign bus.ovf       = flags.ovf;
  assign bus.zero      = flags.zero;
  assign bus.neg       = flags.neg;

endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub: CHUNK=8, 32 and 1 instances behind one
// driver, selected by sel, checked against an arithmetic model.
module tb_seq_add_sub;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   sel;
  logic         in_valid;
  logic         sub;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    res_t         exp;
  } vec_t;

  seq_add_sub_if #(.WIDTH(W)) i8 (), i32 (), i1 ();

  seq_add_sub #(.WIDTH(W), .CHUNK(8)) u8 (
    .clk (clk), .rst (rst), .bus (i8)
  );
  seq_add_sub #(.WIDTH(W), .CHUNK(32)) u32 (
    .clk (clk), .rst (rst), .bus (i32)
  );
  seq_add_sub #(.WIDTH(W), .CHUNK(1)) u1 (
    .clk (clk), .rst (rst), .bus (i1)
  );

  assign i8.in_valid  = in_valid && (sel == 2'd0);
  assign i8.a         = a;
  assign i8.b         = b;
  assign i8.sub       = sub;
  assign i8.out_ready = out_ready;
  assign i32.in_valid  = in_valid && (sel == 2'd1);
  assign i32.a         = a;
  assign i32.b         = b;
  assign i32.sub       = sub;
  assign i32.out_ready = out_ready;
  assign i1.in_valid  = in_valid && (sel == 2'd2);
  assign i1.a         = a;
  assign i1.b         = b;
  assign i1.sub       = sub;
  assign i1.out_ready = out_ready;

  logic [37:0] o8, o32, o1, o;
  assign o8  = {i8.in_ready, i8.out_valid, i8.sum,
                i8.cout, i8.ovf, i8.zero, i8.neg};
  assign o32 = {i32.in_ready, i32.out_valid, i32.sum,
                i32.cout, i32.ovf, i32.zero, i32.neg};
  assign o1  = {i1.in_ready, i1.out_valid, i1.sum,
                i1.cout, i1.ovf, i1.zero, i1.neg};

  always_comb begin
    case (sel)
      2'd1:    o = o32;
      2'd2:    o = o1;
      default: o = o8;
    endcase
  end

  wire  rdy = o[37];
  wire  vld = o[36];
  res_t cur;
  assign cur = o[35:0];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic cmp(input string nm, input res_t g,
                     input res_t e);
    chk({nm, ".sum"},  64'(g.sum),  64'(e.sum));
    chk({nm, ".cout"}, 64'(g.cout), 64'(e.cout));
    chk({nm, ".ovf"},  64'(g.ovf),  64'(e.ovf));
    chk({nm, ".zero"}, 64'(g.zero), 64'(e.zero));
    chk({nm, ".neg"},  64'(g.neg),  64'(e.neg));
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic s);
    res_t       r;
    longint     sv;
    logic [W:0] full;
    if (!s) begin
      full   = {1'b0, x} + {1'b0, y};
      r.sum  = full[W-1:0];
      r.cout = full[W];
      sv = longint'($signed(x)) + longint'($signed(y));
    end else begin
      r.sum  = x - y;
      r.cout = (x >= y);
      sv = longint'($signed(x)) - longint'($signed(y));
    end
    r.ovf  = (sv != longint'($signed(r.sum)));
    r.zero = (r.sum == '0);
    r.neg  = r.sum[W-1];
    return r;
  endfunction

  function automatic int nch(input logic [1:0] s);
    case (s)
      2'd1:    return 1;
      2'd2:    return 32;
      default: return 4;
    endcase
  endfunction

  function automatic vec_t mk(input logic [W-1:0] x,
                              input logic [W-1:0] y,
                              input logic s,
                              input logic [W-1:0] sm,
                              input logic c, input logic v,
                              input logic z, input logic n);
    vec_t t;
    t.a = x;
    t.b = y;
    t.sub = s;
    t.exp.sum = sm;
    t.exp.cout = c;
    t.exp.ovf = v;
    t.exp.zero = z;
    t.exp.neg = n;
    return t;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic do_op(input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       input logic s,
                       output res_t r, output int lat);
    int n = 0;
    r = '0;
    lat = -1;
    @(negedge clk);
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout got=0 want=1");
      return;
    end
    a = x;
    b = y;
    sub = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = ~s;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!vld && lat < 100);
    if (!vld) begin
      checks++;
      failures++;
      $display("FAIL out_valid_timeout got=0 want=1");
      return;
    end
    r = cur;
  endtask

  vec_t tbl[7];

  initial begin
    res_t r;
    int   lat;
    logic seen;
    logic [W-1:0] x, y;
    logic s;

    sel = 2'd0;
    in_valid = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      #1;
      chk($sformatf("reset_in_ready_c%0d", k), 64'(rdy), 64'd1);
      chk($sformatf("reset_out_valid_c%0d", k), 64'(vld), 64'd0);
      cmp($sformatf("reset_c%0d", k), cur, '0);
    end
    @(negedge clk);
    rst = 1'b0;

    tbl[0] = mk(32'd5, 32'd7, 1'b0, 32'd12, 0, 0, 0, 0);
    tbl[1] = mk(32'hFFFF_FFFF, 32'd1, 1'b0,
                32'h0, 1, 0, 1, 0);
    tbl[2] = mk(32'h7FFF_FFFF, 32'd1, 1'b0,
                32'h8000_0000, 0, 1, 0, 1);
    tbl[3] = mk(32'd3, 32'd5, 1'b1,
                32'hFFFF_FFFE, 0, 0, 0, 1);
    tbl[4] = mk(32'h8000_0000, 32'd1, 1'b1,
                32'h7FFF_FFFF, 1, 1, 0, 0);
    tbl[5] = mk(32'h0000_1234, 32'd0, 1'b1,
                32'h0000_1234, 1, 0, 0, 0);
    tbl[6] = mk(32'd5, 32'd5, 1'b1, 32'h0, 1, 0, 1, 0);

    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      for (int i = 0; i < 7; i++) begin
        do_op(tbl[i].a, tbl[i].b, tbl[i].sub, r, lat);
        chk($sformatf("vec%0d_c%0d.latency", i, k),
            64'(lat), 64'(nch(sel)));
        cmp($sformatf("vec%0d_c%0d", i, k), r, tbl[i].exp);
      end
    end

    // Abort in the 2nd RUN cycle; flags are nonzero from 5-5.
    sel = 2'd0;
    @(negedge clk);
    while (!rdy) @(negedge clk);
    a = 32'h11;
    b = 32'h22;
    sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", 64'(rdy), 64'd1);
    chk("abort_out_valid", 64'(vld), 64'd0);
    cmp("abort", cur, '0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (vld) seen = 1'b1;
    end
    chk("abort_no_result", 64'(seen), 64'd0);

    // Backpressure in DONE with ignored in_valid pulses.
    out_ready = 1'b0;
    do_op(32'h10, 32'h20, 1'b0, r, lat);
    cmp("bp_result", r, model(32'h10, 32'h20, 1'b0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = W'(k + 1);
      b = W'(k + 7);
      sub = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d.out_valid", k), 64'(vld), 64'd1);
      chk($sformatf("bp_hold%0d.in_ready", k), 64'(rdy), 64'd0);
      cmp($sformatf("bp_hold%0d", k), cur,
          model(32'h10, 32'h20, 1'b0));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release.out_valid", 64'(vld), 64'd0);
    chk("bp_release.in_ready", 64'(rdy), 64'd1);
    cmp("bp_release_hold", cur, model(32'h10, 32'h20, 1'b0));
    do_op(32'd100, 32'd58, 1'b1, r, lat);
    chk("bp_next.latency", 64'(lat), 64'd4);
    cmp("bp_next", r, model(32'd100, 32'd58, 1'b1));

    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      for (int i = 0; i < 1000; i++) begin
        x = pick();
        y = pick();
        s = 1'($urandom_range(0, 1));
        do_op(x, y, s, r, lat);
        chk($sformatf("rnd_c%0d.latency", k),
            64'(lat), 64'(nch(sel)));
        cmp($sformatf("rnd_c%0d_%0h_%0h_%0d", k, x, y, s),
            r, model(x, y, s));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
